// File: rtl/loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM states,
// bytes per instruction word and the default instruction address width.
package loader_pkg;

  typedef enum logic [2:0] {
    ST_HDR  = 3'd0,
    ST_DATA = 3'd1,
    ST_CSUM = 3'd2,
    ST_RUN  = 3'd3,
    ST_DONE = 3'd4,
    ST_ERR  = 3'd5
  } loader_state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_CNT_W     = $clog2(BYTES_PER_WORD);
  localparam int DEFAULT_ADDR_W = 17;

endpackage

// File: rtl/inst_mem_loader_byte_assembler.sv
// Big-endian byte-to-word assembler. Bytes shift in MSB first; the 4th byte
// of a word is presented combinationally together with a one-cycle
// word-valid strobe. A synchronous clear restarts word alignment; a clear
// that coincides with a valid byte keeps that byte as byte 0 of a new word.
module byte_assembler
  import loader_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_clear,
  input  logic        i_valid,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_word_valid
);

  logic [23:0]           r_shift;
  logic [BYTE_CNT_W-1:0] r_cnt;

  // Word is the three buffered bytes plus the byte arriving now.
  always_comb begin
    o_word       = {r_shift, i_byte};
    o_word_valid = i_valid && !i_clear &&
                   (r_cnt == BYTE_CNT_W'(BYTES_PER_WORD - 1));
  end

  // Shift register and byte position; the counter wraps after the 4th byte.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (i_clear) begin
      r_shift <= i_valid ? {16'h0000, i_byte} : 24'h000000;
      r_cnt   <= i_valid ? BYTE_CNT_W'(1) : '0;
    end else if (i_valid) begin
      r_shift <= {r_shift[15:0], i_byte};
      r_cnt   <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/inst_mem_loader.sv
// Instruction-memory loader. Receives a UART byte stream (word count N,
// then N big-endian words), writes the words to instruction BRAM while the
// core is held in reset, then hands the BRAM address port to the fetch
// stage and releases the core. After the core halts, a new stream reloads.
// Optional feature macro: LOADER_CHECKSUM_EN adds a trailing XOR checksum
// byte over all instruction bytes; a mismatch parks the loader in ERR.
module inst_mem_loader
  import loader_pkg::*;
#(
  parameter int                ADDR_W    = DEFAULT_ADDR_W,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_rx_valid,
  input  logic [7:0]        i_rx_data,
  input  logic [ADDR_W-1:0] i_fetch_addr,
  input  logic              i_core_halt,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  output logic              o_mem_we,
  output logic              o_core_rstn,
  output logic              o_fetch_enable,
  output logic              o_loaded,
  output logic              o_error
);

  loader_state_t r_state;
  loader_state_t w_next_state;

  logic [ADDR_W:0]   r_word_idx;
  logic [ADDR_W:0]   r_word_count;
  logic [ADDR_W:0]   w_idx_next;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [31:0]       r_mem_wdata;
  logic              r_mem_we;

  logic              w_data_active;
  logic              w_asm_valid;
  logic              w_reload;
  logic [31:0]       w_word;
  logic              w_word_valid;
  logic              w_hdr_oversize;
  logic              w_hdr_zero;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        r_csum;
`endif

  // Byte routing: data bytes are only accepted while words remain, and a
  // byte arriving in DONE restarts the stream as header byte 0.
  always_comb begin
    w_data_active  = (r_state == ST_DATA) && (r_word_idx != r_word_count);
    w_reload       = (r_state == ST_DONE) && i_rx_valid;
    w_asm_valid    = i_rx_valid &&
                     ((r_state == ST_HDR) || w_data_active || (r_state == ST_DONE));
    w_idx_next     = r_word_idx + 1'b1;
    w_hdr_oversize = ({1'b0, w_word} > (33'd1 << ADDR_W));
    w_hdr_zero     = (w_word == 32'h0000_0000);
  end

  byte_assembler u_byte_assembler (
    .i_clk        (i_clk),
    .i_rstn       (i_rstn),
    .i_clear      (w_reload),
    .i_valid      (w_asm_valid),
    .i_byte       (i_rx_data),
    .o_word       (w_word),
    .o_word_valid (w_word_valid)
  );

  // State register.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state <= ST_HDR;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic and state-decoded outputs; RUN/DONE give the address
  // port to the fetch stage combinationally.
  always_comb begin
    w_next_state   = r_state;
    o_mem_addr     = r_mem_addr;
    o_core_rstn    = 1'b0;
    o_fetch_enable = 1'b0;
    o_loaded       = 1'b0;
    o_error        = 1'b0;
    case (r_state)
      ST_HDR: begin
        if (w_word_valid) begin
          if (w_hdr_oversize) begin
            w_next_state = ST_ERR;
          end else if (w_hdr_zero) begin
`ifdef LOADER_CHECKSUM_EN
            w_next_state = ST_CSUM;
`else
            w_next_state = ST_RUN;
`endif
          end else begin
            w_next_state = ST_DATA;
          end
        end
      end
      ST_DATA: begin
`ifdef LOADER_CHECKSUM_EN
        if (w_word_valid && (w_idx_next == r_word_count)) begin
          w_next_state = ST_CSUM;
        end
`else
        if (r_word_idx == r_word_count) begin
          w_next_state = ST_RUN;
        end
`endif
      end
`ifdef LOADER_CHECKSUM_EN
      ST_CSUM: begin
        if (i_rx_valid) begin
          w_next_state = (i_rx_data == r_csum) ? ST_RUN : ST_ERR;
        end
      end
`endif
      ST_RUN: begin
        o_mem_addr     = i_fetch_addr;
        o_core_rstn    = 1'b1;
        o_fetch_enable = 1'b1;
        o_loaded       = 1'b1;
        if (i_core_halt) begin
          w_next_state = ST_DONE;
        end
      end
      ST_DONE: begin
        o_mem_addr  = i_fetch_addr;
        o_core_rstn = 1'b1;
        o_loaded    = 1'b1;
        if (i_rx_valid) begin
          w_next_state = ST_HDR;
        end
      end
      ST_ERR: begin
        o_error = 1'b1;
      end
      default: begin
        w_next_state = ST_HDR;
      end
    endcase
  end

  // Load datapath: word count capture, registered BRAM write port and
  // word index; a reload from DONE restarts everything at BASE_ADDR.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_word_idx   <= '0;
      r_word_count <= '0;
      r_mem_addr   <= BASE_ADDR;
      r_mem_wdata  <= '0;
      r_mem_we     <= 1'b0;
    end else begin
      r_mem_we <= 1'b0;
      if (w_reload) begin
        r_word_idx   <= '0;
        r_word_count <= '0;
        r_mem_addr   <= BASE_ADDR;
      end else if ((r_state == ST_HDR) && w_word_valid) begin
        r_word_count <= w_word[ADDR_W:0];
      end else if ((r_state == ST_DATA) && w_word_valid) begin
        r_mem_we    <= 1'b1;
        r_mem_wdata <= w_word;
        r_mem_addr  <= BASE_ADDR + r_word_idx[ADDR_W-1:0];
        r_word_idx  <= w_idx_next;
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  // Running XOR over every accepted instruction byte.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_csum <= '0;
    end else if (w_reload) begin
      r_csum <= '0;
    end else if (w_data_active && i_rx_valid) begin
      r_csum <= r_csum ^ i_rx_data;
    end
  end
`endif

  assign o_mem_wdata = r_mem_wdata;
  assign o_mem_we    = r_mem_we;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Directed testbench for inst_mem_loader. Inputs change on the falling
// clock edge and outputs are checked there, away from the rising edge.
// Build with LOADER_CHECKSUM_EN defined to exercise the checksum path.
module tb_inst_mem_loader;

  logic        clk = 1'b0;
  logic        rstn;
  logic        rxValid;
  logic [7:0]  rxData;
  logic [16:0] fetchAddr;
  logic        coreHalt;
  logic [16:0] memAddr;
  logic [31:0] memWdata;
  logic        memWe;
  logic        coreRstn;
  logic        fetchEnable;
  logic        loaded;
  logic        errorOut;

  int totalChecks = 0;
  int badChecks   = 0;

  logic [16:0] wrAddr[$];
  logic [31:0] wrData[$];

  inst_mem_loader #(.ADDR_W(17), .BASE_ADDR(17'h0)) dut (
    .i_clk          (clk),
    .i_rstn         (rstn),
    .i_rx_valid     (rxValid),
    .i_rx_data      (rxData),
    .i_fetch_addr   (fetchAddr),
    .i_core_halt    (coreHalt),
    .o_mem_addr     (memAddr),
    .o_mem_wdata    (memWdata),
    .o_mem_we       (memWe),
    .o_core_rstn    (coreRstn),
    .o_fetch_enable (fetchEnable),
    .o_loaded       (loaded),
    .o_error        (errorOut)
  );

  // 100 MHz clock.
  always #5 clk = ~clk;

  // Record every BRAM write seen on the port.
  always @(negedge clk) begin
    if (rstn && memWe) begin
      wrAddr.push_back(memAddr);
      wrData.push_back(memWdata);
    end
  end

  // Hard stop in case something stalls the sequence.
  initial begin
    #1000000;
    $display("[TB] FAIL timeout: sequence did not complete");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    totalChecks++;
    if (actual !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Present one byte for exactly one cycle, returning on the next falling edge.
  task automatic applyStimulus(input logic [7:0] b);
    rxValid = 1'b1;
    rxData  = b;
    @(negedge clk);
    rxValid = 1'b0;
  endtask

  task automatic sendWord(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) begin
      applyStimulus(w[8*i +: 8]);
    end
  endtask

  // Stream tail: the checksum byte when enabled, otherwise one idle cycle.
  task automatic sendTail(input logic [7:0] c);
`ifdef LOADER_CHECKSUM_EN
    applyStimulus(c);
`else
    if (c === 8'hxx) rxData = 8'h00;
    @(negedge clk);
`endif
  endtask

  task automatic checkWrite(input int idx, input logic [16:0] a, input logic [31:0] d);
    if (wrAddr.size() > idx) begin
      checkOutput($sformatf("wr%0d_addr", idx), wrAddr[idx], a);
      checkOutput($sformatf("wr%0d_data", idx), wrData[idx], d);
    end else begin
      checkOutput($sformatf("wr%0d_present", idx), wrAddr.size(), idx + 1);
    end
  endtask

  task automatic doReset();
    rstn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    wrAddr.delete();
    wrData.delete();
  endtask

  initial begin
    rstn      = 1'b0;
    rxValid   = 1'b0;
    rxData    = 8'h00;
    fetchAddr = 17'h0;
    coreHalt  = 1'b0;

    // Reset values, then idling with no input keeps the core in reset.
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_mem_addr", memAddr, 17'h0);
    checkOutput("rst_mem_wdata", memWdata, 32'h0);
    checkOutput("rst_mem_we", memWe, 1'b0);
    checkOutput("rst_core_rstn", coreRstn, 1'b0);
    checkOutput("rst_fetch_en", fetchEnable, 1'b0);
    checkOutput("rst_loaded", loaded, 1'b0);
    checkOutput("rst_error", errorOut, 1'b0);
    rstn = 1'b1;
    repeat (8) @(negedge clk);
    checkOutput("idle_core_rstn", coreRstn, 1'b0);
    checkOutput("idle_fetch_en", fetchEnable, 1'b0);
    checkOutput("idle_mem_we", memWe, 1'b0);
    checkOutput("idle_loaded", loaded, 1'b0);

    // Two-word program, bytes back to back.
    doReset();
    sendWord(32'h0000_0002);
    sendWord(32'h2001_0005);
    checkOutput("p2_w0_we", memWe, 1'b1);
    checkOutput("p2_w0_addr", memAddr, 17'h0);
    checkOutput("p2_w0_data", memWdata, 32'h2001_0005);
    sendWord(32'h0000_0000);
    checkOutput("p2_w1_we", memWe, 1'b1);
    checkOutput("p2_w1_addr", memAddr, 17'h1);
    checkOutput("p2_w1_data", memWdata, 32'h0);
    checkOutput("p2_w1_core_rstn", coreRstn, 1'b0);
    checkOutput("p2_w1_fetch_en", fetchEnable, 1'b0);
    sendTail(8'h24);
    checkOutput("p2_run_core_rstn", coreRstn, 1'b1);
    checkOutput("p2_run_fetch_en", fetchEnable, 1'b1);
    checkOutput("p2_run_loaded", loaded, 1'b1);
    checkOutput("p2_run_we", memWe, 1'b0);
    fetchAddr = 17'h1;
    #1;
    checkOutput("p2_fetch_addr1", memAddr, 17'h1);
    fetchAddr = 17'h0ABCD;
    #1;
    checkOutput("p2_fetch_addr2", memAddr, 17'h0ABCD);
    @(negedge clk);
    checkOutput("p2_write_count", wrAddr.size(), 2);
    checkWrite(0, 17'h0, 32'h2001_0005);
    checkWrite(1, 17'h1, 32'h0000_0000);

    // Empty program goes straight to RUN with no writes.
    doReset();
    sendWord(32'h0000_0000);
`ifdef LOADER_CHECKSUM_EN
    checkOutput("n0_csum_wait", fetchEnable, 1'b0);
    applyStimulus(8'h00);
`endif
    checkOutput("n0_fetch_en", fetchEnable, 1'b1);
    checkOutput("n0_loaded", loaded, 1'b1);
    @(negedge clk);
    checkOutput("n0_write_count", wrAddr.size(), 0);

`ifdef LOADER_CHECKSUM_EN
    // Good and bad checksum byte after a single word.
    doReset();
    sendWord(32'h0000_0001);
    sendWord(32'h1234_5678);
    applyStimulus(8'h08);
    checkOutput("cs_good_fetch_en", fetchEnable, 1'b1);
    checkOutput("cs_good_error", errorOut, 1'b0);
    doReset();
    sendWord(32'h0000_0001);
    sendWord(32'h1234_5678);
    applyStimulus(8'h09);
    checkOutput("cs_bad_error", errorOut, 1'b1);
    checkOutput("cs_bad_core_rstn", coreRstn, 1'b0);
    sendWord(32'h0000_0000);
    checkOutput("cs_bad_sticky", errorOut, 1'b1);
    checkOutput("cs_bad_core_rstn2", coreRstn, 1'b0);
`endif

    // Oversize word count: one beyond the address space.
    doReset();
    sendWord(32'h0002_0001);
    checkOutput("big_error", errorOut, 1'b1);
    checkOutput("big_core_rstn", coreRstn, 1'b0);
    checkOutput("big_fetch_en", fetchEnable, 1'b0);
    sendWord(32'h0000_0000);
    checkOutput("big_sticky", errorOut, 1'b1);
    checkOutput("big_write_count", wrAddr.size(), 0);

    // Exactly the full address space is accepted.
    doReset();
    sendWord(32'h0002_0000);
    checkOutput("max_error", errorOut, 1'b0);
    checkOutput("max_loaded", loaded, 1'b0);

    // Halt, then reload from DONE.
    doReset();
    sendWord(32'h0000_0001);
    sendWord(32'h1122_3344);
    sendTail(8'h44);
    checkOutput("h_run_fetch_en", fetchEnable, 1'b1);
    wrAddr.delete();
    wrData.delete();
    coreHalt = 1'b1;
    rxValid  = 1'b1;
    rxData   = 8'hFF;
    @(negedge clk);
    coreHalt = 1'b0;
    rxValid  = 1'b0;
    checkOutput("h_done_fetch_en", fetchEnable, 1'b0);
    checkOutput("h_done_core_rstn", coreRstn, 1'b1);
    checkOutput("h_done_loaded", loaded, 1'b1);
    fetchAddr = 17'h0155;
    #1;
    checkOutput("h_done_mem_addr", memAddr, 17'h0155);
    @(negedge clk);
    checkOutput("h_done_hold", fetchEnable, 1'b0);
    applyStimulus(8'h00);
    checkOutput("h_reload_core_rstn", coreRstn, 1'b0);
    checkOutput("h_reload_loaded", loaded, 1'b0);
    applyStimulus(8'h00);
    applyStimulus(8'h00);
    applyStimulus(8'h01);
    sendWord(32'hDEAD_BEEF);
    checkOutput("h_wr_we", memWe, 1'b1);
    checkOutput("h_wr_addr", memAddr, 17'h0);
    checkOutput("h_wr_data", memWdata, 32'hDEAD_BEEF);
    sendTail(8'h22);
    checkOutput("h_rerun_fetch_en", fetchEnable, 1'b1);
    checkOutput("h_rerun_error", errorOut, 1'b0);
    @(negedge clk);
    checkOutput("h_write_count", wrAddr.size(), 1);

    // Asynchronous reset during the second write of a three-word load.
    doReset();
    sendWord(32'h0000_0003);
    sendWord(32'hCAFE_F00D);
    sendWord(32'h0102_0304);
    checkOutput("ar_pre_we", memWe, 1'b1);
    checkOutput("ar_pre_addr", memAddr, 17'h1);
    #2;
    rstn = 1'b0;
    #1;
    checkOutput("ar_we", memWe, 1'b0);
    checkOutput("ar_addr", memAddr, 17'h0);
    checkOutput("ar_wdata", memWdata, 32'h0);
    checkOutput("ar_core_rstn", coreRstn, 1'b0);
    @(negedge clk);
    rstn = 1'b1;
    wrAddr.delete();
    wrData.delete();
    sendWord(32'h0000_0001);
    sendWord(32'hA55A_0FF0);
    checkOutput("ar_new_we", memWe, 1'b1);
    checkOutput("ar_new_addr", memAddr, 17'h0);
    checkOutput("ar_new_data", memWdata, 32'hA55A_0FF0);
    sendTail(8'h00);
    checkOutput("ar_new_fetch_en", fetchEnable, 1'b1);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule

// File: doc/inst_mem_loader.md
# inst_mem_loader

Controller that owns the instruction-memory port during program load and then hands it to the fetch stage. It assembles a UART byte stream into 32-bit words, writes them to instruction BRAM, holds the core in reset while loading, and releases the core (reset deassert plus fetch enable) once the program is complete. It sits between the UART receiver, the instruction BRAM and the core's fetch stage.

## Interface
- ADDR_W, 17, instruction word-address width (matches the fetch stage's 17-bit instruction address)
- BASE_ADDR, 0, first word address written by the loader
- clk  in  1  core clock
- rstn  in  1  asynchronous active-low reset
- rx_valid  in  1  one-cycle strobe: rx_data holds a received byte
- rx_data  in  8  received byte
- fetch_addr  in  ADDR_W  instruction address from the fetch stage
- core_halt  in  1  level: the core has executed its halt instruction
- mem_addr  out  ADDR_W  instruction BRAM address
- mem_wdata  out  32  instruction BRAM write data
- mem_we  out  1  instruction BRAM write enable
- core_rstn  out  1  active-low reset to the core pipeline
- fetch_enable  out  1  drives the fetch stage's enable and pcenable
- loaded  out  1  high in RUN and DONE
- error  out  1  high in ERR

## Operation
- Stream format: 4-byte big-endian word count N, then N big-endian instruction words. With LOADER_CHECKSUM_EN, one XOR checksum byte over all instruction bytes follows.
- State HDR (entered on reset):
  - Collect 4 bytes into N.
  - N==0: go to CSUM (macro on) or RUN (macro off).
  - N > 2^ADDR_W: go to ERR.
  - Otherwise go to DATA.
- State DATA:
  - 2-bit byte counter plus word counter (ADDR_W+1 bits).
  - On the 4th byte, write the word to BASE_ADDR+index and increment the index.
  - After the N-th write, go to CSUM or RUN.
- State CSUM:
  - Compare the next byte with the running XOR.
  - Equal: go to RUN. Otherwise go to ERR.
- State RUN:
  - mem_addr = fetch_addr, mem_we = 0, core_rstn = 1, fetch_enable = 1.
  - rx_valid is ignored.
  - When core_halt is 1, go to DONE.
- State DONE:
  - fetch_enable = 0, core_rstn = 1, mem_addr = fetch_addr.
  - The first rx_valid is taken as header byte 0, and the block goes to HDR with the byte counter at 1.
- State ERR:
  - Core held in reset, error = 1.
  - Left only via rstn.
- In HDR, DATA and CSUM:
  - core_rstn = 0, fetch_enable = 0.
  - mem_addr = write address.
- Word address wraps modulo 2^ADDR_W. This matters only when BASE_ADDR is nonzero; N is bounded by the HDR check.
- rx_valid and core_halt in the same cycle in RUN: core_halt wins and the byte is dropped.

## Timing
- Reset values:
  - mem_addr = BASE_ADDR, mem_wdata = 0, mem_we = 0.
  - core_rstn = 0, fetch_enable = 0, loaded = 0, error = 0.
  - All counters 0, state HDR.
- mem_we, mem_wdata and mem_addr are registered. They are valid for exactly one cycle, in the cycle after the rx_valid carrying the word's 4th byte.
- Entry to RUN takes effect in the cycle after the final byte or the final write, whichever is later. core_rstn, fetch_enable and loaded rise together in that cycle.
- The RUN mem_addr path from fetch_addr is combinational (zero latency). The fetch stage sees BRAM data with its normal latency.
- DONE: fetch_enable falls in the cycle after core_halt is sampled high.
- rstn asserted mid-load: everything returns to reset values immediately. Partially written memory is not cleared.
- Back-to-back rx_valid on consecutive cycles is supported.

## Configuration
- LOADER_CHECKSUM_EN:
  - Defined: the CSUM state and an 8-bit XOR accumulator are present. A mismatching checksum byte leads to ERR.
  - Undefined: CSUM and the accumulator are absent. The last data word goes straight to RUN, and ERR is reachable only through the oversize-N check.

## Structure
- Shared package loader_pkg holds:
  - State enum (HDR, DATA, CSUM, RUN, DONE, ERR).
  - Byte-count constant 4.
  - Default ADDR_W.
- Sub-module byte_assembler:
  - Shifts in bytes.
  - Outputs a 32-bit word and a one-cycle word_valid every 4th byte.
  - Has a sync clear used on HDR entry and on reload from DONE.
- The top holds the FSM, the word counter, the checksum and the output muxes.

## Test plan
- Reset, then no input → core_rstn=0, fetch_enable=0, mem_we=0, loaded=0 indefinitely.
- Stream N=2, words 0x20010005 and 0x00000000 (macro off) → two mem_we pulses at addresses 0 and 1 with that data. The cycle after the second write: core_rstn=1, fetch_enable=1. fetch_addr=0x1 then appears on mem_addr the same cycle.
- N=0 (macro off) → RUN one cycle after the 4th header byte, with no mem_we.
- Macro on, N=1, word 0x12345678, checksum 0x08 → RUN. Same stream with checksum 0x09 → ERR, error=1, core_rstn stays 0 until rstn.
- N=0x00020001 → ERR with no writes.
- In RUN, assert core_halt → fetch_enable=0 next cycle. Then send N=1, word 0xDEADBEEF → write at BASE_ADDR, then RUN again. rstn pulsed mid-DATA → all outputs return to reset values and the next byte is taken as header byte 0.
